// File: rtl/rv32i_alu.sv
// RV32I integer ALU: eight-operation combinational result plus a registered copy with valid.
// Optional flags (zero/neg/carry/ovf and registered flags_q) are compiled in with `define ALU_FLAGS_EN.

package rv32i_types;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SRA = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_ops;
endpackage

module rv32i_alu
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_q,
  output logic             f_q_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic [3:0]       flags_q
`endif
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W1  = WIDTH + 1;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_f;
  logic [SHW-1:0]   w_shamt;

  logic [WIDTH-1:0] r_f_q;
  logic             r_f_q_valid;

  // One adder serves both add and sub: a - b is formed as a + ~b + 1.
  assign w_sub  = (aluop == ALU_SUB);
  assign w_b_op = w_sub ? ~b : b;

`ifdef ALU_FLAGS_EN
  logic w_carry_out;
  assign {w_carry_out, w_sum} = {1'b0, a} + {1'b0, w_b_op} + W1'(w_sub);
`else
  assign w_sum = a + w_b_op + WIDTH'(w_sub);
`endif

  assign w_shamt = b[SHW-1:0];
  assign w_sll   = a << w_shamt;
  assign w_srl   = a >> w_shamt;
  assign w_sra   = $unsigned($signed(a) >>> w_shamt);

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path through the block can infer a latch.
  always_comb begin
    w_f = '0;
    case (aluop)
      ALU_ADD, ALU_SUB: w_f = w_sum;
      ALU_SLL:          w_f = w_sll;
      ALU_SRA:          w_f = w_sra;
      ALU_XOR:          w_f = a ^ b;
      ALU_SRL:          w_f = w_srl;
      ALU_OR:           w_f = a | b;
      ALU_AND:          w_f = a & b;
      default:          w_f = '0;
    endcase
  end

  assign f = w_f;

`ifdef ALU_FLAGS_EN
  logic w_arith;
  logic w_zero;
  logic w_neg;
  logic w_carry;
  logic w_ovf;
  logic [3:0] r_flags_q;

  assign w_arith = (aluop == ALU_ADD) || (aluop == ALU_SUB);
  assign w_zero  = (w_f == '0);
  assign w_neg   = w_f[WIDTH-1];
  // For sub the adder carry-out is the not-borrow, i.e. a >= b unsigned.
  assign w_carry = w_arith & w_carry_out;
  assign w_ovf   = w_arith & (a[WIDTH-1] == w_b_op[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);

  assign zero  = w_zero;
  assign neg   = w_neg;
  assign carry = w_carry;
  assign ovf   = w_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags_q <= '0;
    end else if (in_valid) begin
      r_flags_q <= {w_ovf, w_carry, w_neg, w_zero};
    end
  end

  assign flags_q = r_flags_q;
`endif

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_q       <= '0;
      r_f_q_valid <= 1'b0;
    end else begin
      r_f_q_valid <= in_valid;
      if (in_valid) begin
        r_f_q <= w_f;
      end
    end
  end

  assign f_q       = r_f_q;
  assign f_q_valid = r_f_q_valid;

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed vectors, random sweep of all
// eight operations against an arithmetic reference, and registered-copy checks.
`timescale 1ns/1ps

module tb_rv32i_alu;
  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic [2:0]    aluop;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic [W-1:0]  f;
  logic [W-1:0]  f_q;
  logic          f_q_valid;
`ifdef ALU_FLAGS_EN
  logic          zero;
  logic          neg;
  logic          carry;
  logic          ovf;
  logic [3:0]    flags_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .f         (f),
    .f_q       (f_q),
    .f_q_valid (f_q_valid)
`ifdef ALU_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .flags_q   (flags_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference result from the operation definitions, using plain arithmetic.
  function automatic logic [W-1:0] ref_f(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned s;
    logic [W-1:0] fill;
    s = y % 32;
    fill = 32'hFFFF_FFFF;
    case (op)
      0: return x + y;
      1: return x << s;
      2: return (x >> s) | (x[W-1] ? ~(fill >> s) : 32'h0);
      3: return x - y;
      4: return x ^ y;
      5: return x >> s;
      6: return x | y;
      default: return x & y;
    endcase
  endfunction

`ifdef ALU_FLAGS_EN
  function automatic logic [3:0] ref_flags(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    longint sx, sy, sr;
    logic c, v;
    r  = ref_f(op, x, y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c  = 1'b0;
    v  = 1'b0;
    if (op == 0) begin
      c  = ({32'h0, x} + {32'h0, y}) > 64'h0000_0000_FFFF_FFFF;
      sr = sx + sy;
      v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else if (op == 3) begin
      c  = (x >= y);
      sr = sx - sy;
      v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    return {v, c, r[W-1], (r == 32'h0)};
  endfunction
`endif

  task automatic comb(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] exp_f);
    aluop = op;
    a = x;
    b = y;
    #1;
    check(tag, f, exp_f);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] exp_q;
    logic         exp_v;
`ifdef ALU_FLAGS_EN
    logic [3:0]   exp_fl;
    logic [3:0]   exp_flq;
    exp_flq = 4'h0;
`endif

    rst = 1'b0;
    aluop = 3'b000;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    #2;
    check("reset_f_q", f_q, 32'h0);
    check("reset_valid", {31'h0, f_q_valid}, 32'h0);
`ifdef ALU_FLAGS_EN
    check("reset_flags_q", {28'h0, flags_q}, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;

    comb("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0);
`ifdef ALU_FLAGS_EN
    check("add_wrap_zero", {31'h0, zero}, 32'h1);
    check("add_wrap_carry", {31'h0, carry}, 32'h1);
    check("add_wrap_ovf", {31'h0, ovf}, 32'h0);
`endif
    comb("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
`ifdef ALU_FLAGS_EN
    check("add_ovf_ovf", {31'h0, ovf}, 32'h1);
    check("add_ovf_neg", {31'h0, neg}, 32'h1);
`endif
    comb("sub_neg", 3'b011, 32'd5, 32'd7, 32'hFFFF_FFFE);
`ifdef ALU_FLAGS_EN
    check("sub_neg_carry", {31'h0, carry}, 32'h0);
    check("sub_neg_neg", {31'h0, neg}, 32'h1);
`endif
    comb("sub_pos", 3'b011, 32'd7, 32'd5, 32'd2);
`ifdef ALU_FLAGS_EN
    check("sub_pos_carry", {31'h0, carry}, 32'h1);
`endif
    comb("sll_4", 3'b001, 32'h8000_0010, 32'h0000_0024, 32'h0000_0100);
    comb("srl_4", 3'b101, 32'h8000_0010, 32'h0000_0024, 32'h0800_0001);
    comb("sra_4", 3'b010, 32'h8000_0010, 32'h0000_0024, 32'hF800_0001);
    comb("sll_0", 3'b001, 32'h8000_0010, 32'd32, 32'h8000_0010);
    comb("srl_0", 3'b101, 32'h8000_0010, 32'd32, 32'h8000_0010);
    comb("sra_0", 3'b010, 32'h8000_0010, 32'd32, 32'h8000_0010);
    comb("sra_31", 3'b010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    comb("xor", 3'b100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
    comb("or",  3'b110, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
    comb("and", 3'b111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);

    // Unknown select: only meaningful on a four-state simulator.
    aluop = 3'bxxx;
    a = 32'h1234_5678;
    b = 32'h0000_0001;
    #1;
    if ($isunknown(aluop)) check("op_x", f, 32'h0);

    // Registered copy, valid, and asynchronous reset.
    @(negedge clk);
    aluop = 3'b000;
    a = 32'd3;
    b = 32'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("reg_capture", f_q, 32'd7);
    check("reg_valid1", {31'h0, f_q_valid}, 32'h1);
    @(negedge clk);
    a = 32'd10;
    b = 32'd20;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reg_hold", f_q, 32'd7);
    check("reg_valid0", {31'h0, f_q_valid}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_f_q", f_q, 32'h0);
    check("arst_valid", {31'h0, f_q_valid}, 32'h0);
    check("arst_f_live", f, 32'd30);
    a = 32'd1;
    b = 32'd2;
    #1;
    check("arst_f_track", f, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    a = 32'd100;
    b = 32'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_capture", f_q, 32'd101);
    check("post_rst_valid", {31'h0, f_q_valid}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;

    // Random sweep of all eight operations.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      a = ra;
      b = rb;
      for (int op = 0; op < 8; op++) begin
        aluop = 3'(op);
        #1;
        check("sweep_f", f, ref_f(op, ra, rb));
`ifdef ALU_FLAGS_EN
        exp_fl = ref_flags(op, ra, rb);
        check("sweep_flags", {28'h0, ovf, carry, neg, zero}, {28'h0, exp_fl});
`endif
      end
    end

    // Random registered traffic with a sparse valid.
    @(negedge clk);
    exp_q = f_q;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      aluop = 3'($urandom_range(0, 7));
      a = ra;
      b = rb;
      in_valid = 1'($urandom_range(0, 1));
      exp_v = in_valid;
      if (in_valid) begin
        exp_q = ref_f(int'(aluop), ra, rb);
`ifdef ALU_FLAGS_EN
        exp_flq = ref_flags(int'(aluop), ra, rb);
`endif
      end
      @(posedge clk);
      #1;
      check("rand_f_q", f_q, exp_q);
      check("rand_valid", {31'h0, f_q_valid}, {31'h0, exp_v});
`ifdef ALU_FLAGS_EN
      check("rand_flags_q", {28'h0, flags_q}, {28'h0, exp_flq});
`endif
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
